// File: rtl/ex_alu_adder_unit.sv
// Execute-stage arithmetic: registered 64-bit ALU with zero flag, plus the
// combinational PC+4 and branch-target adders feeding the PC mux.
module ex_alu_adder_unit #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] alu_out,
   output logic             zero,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] branch_target
);

   localparam int unsigned SHW = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] result_c;

   assign shamt = alu_b[SHW-1:0];

   // ALU operation decode
   always_comb begin
      result_c = '0;
      case (alu_sel)
         OP_ADD:  result_c = alu_a + alu_b;
         OP_SUB:  result_c = alu_a - alu_b;
         OP_AND:  result_c = alu_a & alu_b;
         OP_OR:   result_c = alu_a | alu_b;
         OP_XOR:  result_c = alu_a ^ alu_b;
         OP_SLL:  result_c = alu_a << shamt;
         OP_SRL:  result_c = alu_a >> shamt;
         OP_SLT:  result_c = WIDTH'($signed(alu_a) < $signed(alu_b));
         default: result_c = '0;
      endcase
   end

   // Result/flag capture; en=0 stalls the stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_out <= '0;
         zero    <= 1'b1;
      end else if (en) begin
         alu_out <= result_c;
         zero    <= (result_c == '0);
      end
   end

   // Next-PC adders, independent of reset; imm<<1 drops imm's top bit
   assign pc_plus4      = pc + WIDTH'(PC_INC);
   assign branch_target = pc + {imm[WIDTH-2:0], 1'b0};

endmodule

// File: tb/tb_ex_alu_adder_unit.sv
// Self-checking bench for ex_alu_adder_unit: directed corner cases plus
// random operations compared against an arithmetic reference model.
module tb_ex_alu_adder_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [2:0]  alu_sel;
   logic [63:0] pc;
   logic [63:0] imm;
   logic [63:0] alu_out;
   logic        zero;
   logic [63:0] pc_plus4;
   logic [63:0] branch_target;

   int unsigned errors;
   int unsigned checks;
   logic [63:0] mdl_out;

   ex_alu_adder_unit dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_sel      (alu_sel),
      .pc           (pc),
      .imm          (imm),
      .alu_out      (alu_out),
      .zero         (zero),
      .pc_plus4     (pc_plus4),
      .branch_target(branch_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference ALU from the operation table
   function automatic logic [63:0] ref_alu(input logic [2:0] sel, input logic [63:0] a,
                                           input logic [63:0] b);
      int unsigned sh;
      longint      sa;
      longint      sb;
      sh = int'(b % 64);
      sa = a;
      sb = b;
      case (sel)
         3'd0:    return a + b;
         3'd1:    return a + (~b) + 64'd1;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << sh;
         3'd6:    return a >> sh;
         default: return (sa < sb) ? 64'd1 : 64'd0;
      endcase
   endfunction

   // Present one op, clock it, then check output and flag against the model
   task automatic step(input string tag, input logic e, input logic [2:0] sel,
                       input logic [63:0] a, input logic [63:0] b);
      en      = e;
      alu_sel = sel;
      alu_a   = a;
      alu_b   = b;
      @(posedge clk);
      #1;
      if (e && rst) mdl_out = ref_alu(sel, a, b);
      check({tag, ".out"}, alu_out, mdl_out);
      check({tag, ".zero"}, 64'(zero), 64'(mdl_out == 64'd0));
   endtask

   task automatic check_adders(input string tag, input logic [63:0] p, input logic [63:0] i);
      pc  = p;
      imm = i;
      #1;
      check({tag, ".pc4"}, pc_plus4, p + 64'd4);
      check({tag, ".bt"}, branch_target, p + i * 64'd2);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      mdl_out = 64'd0;
      rst     = 1'b0;
      en      = 1'b1;
      alu_sel = 3'd0;
      alu_a   = 64'd5;
      alu_b   = 64'd7;
      pc      = 64'd0;
      imm     = 64'd0;

      // Reset holds output at zero while clocking
      repeat (3) @(posedge clk);
      #1;
      check("rst.out", alu_out, 64'd0);
      check("rst.zero", 64'(zero), 64'd1);
      rst = 1'b1;
      step("rel", 1'b1, 3'd0, 64'd5, 64'd7);
      check("rel.12", alu_out, 64'd12);

      // Directed operations
      step("sub0", 1'b1, 3'd1, 64'h10, 64'h10);
      step("subneg", 1'b1, 3'd1, 64'd0, 64'd1);
      check("subneg.val", alu_out, 64'hFFFF_FFFF_FFFF_FFFF);
      step("and", 1'b1, 3'd2, 64'hF0F0, 64'h0FF0);
      check("and.val", alu_out, 64'h00F0);
      step("or", 1'b1, 3'd3, 64'hF0F0, 64'h0FF0);
      check("or.val", alu_out, 64'hFFF0);
      step("xor", 1'b1, 3'd4, 64'hF0F0, 64'h0FF0);
      check("xor.val", alu_out, 64'hFF00);
      step("sll", 1'b1, 3'd5, 64'd1, 64'h43);
      check("sll.val", alu_out, 64'h8);
      step("srl", 1'b1, 3'd6, 64'h8000_0000_0000_0000, 64'd63);
      check("srl.val", alu_out, 64'd1);
      step("slt1", 1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      check("slt1.val", alu_out, 64'd1);
      step("slt2", 1'b1, 3'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      check("slt2.val", alu_out, 64'd0);
      step("slt3", 1'b1, 3'd7, 64'd3, 64'd3);
      check("slt3.val", alu_out, 64'd0);

      // Stall holds 12 for three cycles
      step("cap", 1'b1, 3'd0, 64'd5, 64'd7);
      for (int i = 0; i < 3; i++) begin
         step("stall", 1'b0, 3'd4, 64'(i + 100), 64'h55);
         check("stall.12", alu_out, 64'd12);
      end
      step("unstall", 1'b1, 3'd0, 64'd1, 64'd2);
      check("unstall.3", alu_out, 64'd3);

      // Asynchronous reset between edges
      #2;
      rst = 1'b0;
      #1;
      mdl_out = 64'd0;
      check("arst.out", alu_out, 64'd0);
      check("arst.zero", 64'(zero), 64'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      step("rearm", 1'b1, 3'd3, 64'h30, 64'h3);
      check("rearm.val", alu_out, 64'h33);

      // Adders
      check_adders("add0", 64'h100, 64'h8);
      check("add0.bt.val", branch_target, 64'h110);
      check_adders("add1", 64'h100, 64'hFFFF_FFFF_FFFF_FFFC);
      check("add1.bt.val", branch_target, 64'hF8);
      check_adders("add2", 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
      check("add2.pc4.val", pc_plus4, 64'd0);
      check_adders("add3", 64'h1000, 64'h8000_0000_0000_0004);

      // Random operations, occasional stalls and corner operands
      for (int i = 0; i < 300; i++) begin
         logic [63:0] ra;
         logic [63:0] rb;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: ra = 64'd0;
            1: rb = ra;
            2: ra = 64'h8000_0000_0000_0000;
            3: rb = 64'hFFFF_FFFF_FFFF_FFFF;
            default: ;
         endcase
         step("rnd", ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), ra, rb);
         if (i % 10 == 0) check_adders("rndadd", {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
